// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache main-memory arbiter: state encodings,
// grant identifiers and the default block address/data widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 28;
    localparam int BLOCK_W_DEF = 128;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_SERVE_I = 3'd1,
        ARB_SERVE_D = 3'd2,
        ARB_RESP_I  = 3'd3,
        ARB_RESP_D  = 3'd4
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Two-way round-robin picker: on a conflict the client that did not win last
// time is chosen; a lone requester always wins.
module rr_select
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req_i | req_d;
        if (req_i && req_d) begin
            grant = ~last_grant;
        end else if (req_d) begin
            grant = GRANT_D;
        end else begin
            grant = GRANT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache block reads and D-cache block reads/write-backs onto the
// single main-memory port, returning per-client busywait stalls.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    arb_state_t         state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               started_q, started_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic               write_q, write_d;
    logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;

    logic sel_grant;
    logic sel_valid;

    rr_select u_rr_select (
        .req_i      (I_READ),
        .req_d      (D_READ | D_WRITE),
        .last_grant (last_grant_q),
        .grant      (sel_grant),
        .valid      (sel_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        started_d    = started_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ARB_SERVE_I, ARB_SERVE_D: begin
                // Memory must first show busy, then drop it, before the access counts as done.
                if (!started_q) begin
                    started_d = MEM_BUSYWAIT;
                end else if (!MEM_BUSYWAIT) begin
                    started_d = 1'b0;
                    if (state_q == ARB_SERVE_I) begin
                        i_rdata_d = MEM_READDATA;
                        state_d   = ARB_RESP_I;
                    end else begin
                        if (!write_q) d_rdata_d = MEM_READDATA;
                        state_d = ARB_RESP_D;
                    end
                end
            end
            default: begin
                // IDLE and both RESP states arbitrate, so a pending client is granted with no idle gap.
                state_d = ARB_IDLE;
                if (sel_valid) begin
                    last_grant_d = sel_grant;
                    if (sel_grant == GRANT_D) begin
                        state_d = ARB_SERVE_D;
                        addr_d  = D_ADDRESS;
                        wdata_d = D_WRITEDATA;
                        write_d = D_WRITE;
                    end else begin
                        state_d = ARB_SERVE_I;
                        addr_d  = I_ADDRESS;
                        write_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_I;
            started_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            started_q    <= started_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        MEM_READ      = (state_q == ARB_SERVE_I) || ((state_q == ARB_SERVE_D) && !write_q);
        MEM_WRITE     = (state_q == ARB_SERVE_D) && write_q;
        MEM_ADDRESS   = addr_q;
        MEM_WRITEDATA = wdata_q;
        I_READDATA    = i_rdata_q;
        D_READDATA    = d_rdata_q;
        I_BUSYWAIT    = !RESET && I_READ && (state_q != ARB_RESP_I);
        D_BUSYWAIT    = !RESET && (D_READ || D_WRITE) && (state_q != ARB_RESP_D);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small handshaking memory model.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_READ, D_READ, D_WRITE;
    logic [AW-1:0] I_ADDRESS, D_ADDRESS, MEM_ADDRESS;
    logic [BW-1:0] I_READDATA, D_READDATA, D_WRITEDATA, MEM_WRITEDATA, MEM_READDATA;
    logic          I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;

    int n_vec = 0;
    int n_err = 0;
    int mem_lat = 2;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // Memory model: busy for mem_lat cycles after a strobe, ignores the strobe
    // that is still high on the arbiter's completion edge.
    logic [BW-1:0] tmem [16];
    logic          tvalid [16];
    int            cnt;
    logic          served, m_wr;
    logic [3:0]    m_idx;
    logic [BW-1:0] m_wd;

    function automatic logic [BW-1:0] init_blk(input logic [3:0] idx);
        if (idx == 4'd1) return 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        return {4{32'hA5A5_0000 | {28'd0, idx}}};
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MEM_BUSYWAIT <= 1'b0;
            MEM_READDATA <= '0;
            cnt          <= 0;
            served       <= 1'b0;
            m_wr         <= 1'b0;
            m_idx        <= '0;
            m_wd         <= '0;
            for (int i = 0; i < 16; i++) tvalid[i] <= 1'b0;
        end else if (MEM_BUSYWAIT) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                MEM_BUSYWAIT <= 1'b0;
                served       <= 1'b1;
                if (m_wr) begin
                    tmem[m_idx]   <= m_wd;
                    tvalid[m_idx] <= 1'b1;
                end else begin
                    MEM_READDATA <= tvalid[m_idx] ? tmem[m_idx] : init_blk(m_idx);
                end
            end
        end else if ((MEM_READ || MEM_WRITE) && !served) begin
            MEM_BUSYWAIT <= 1'b1;
            cnt          <= mem_lat;
            m_idx        <= MEM_ADDRESS[7:4];
            m_wr         <= MEM_WRITE;
            m_wd         <= MEM_WRITEDATA;
        end else if (!(MEM_READ || MEM_WRITE)) begin
            served <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Waits for the chosen client's response cycle, noting busywait behaviour on the way.
    task automatic wait_resp(input bit is_d, output int cyc, output bit ibw_low, output bit dbw_high);
        bit done = 1'b0;
        cyc = 0; ibw_low = 1'b0; dbw_high = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (is_d ? ((D_READ || D_WRITE) && !D_BUSYWAIT) : (I_READ && !I_BUSYWAIT)) begin
                done = 1'b1;
            end else begin
                if (!I_BUSYWAIT) ibw_low = 1'b1;
                if (D_BUSYWAIT) dbw_high = 1'b1;
            end
        end
        chk("resp_timeout", {127'd0, !done}, '0);
    endtask

    task automatic wait_any(output bit who);
        bit done = 1'b0;
        int cyc = 0;
        who = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin who = 1'b1; done = 1'b1; end
            else if (I_READ && !I_BUSYWAIT) begin who = 1'b0; done = 1'b1; end
        end
        chk("any_timeout", {127'd0, !done}, '0);
    endtask

    initial begin
        int  cyc;
        bit  ibw_low, dbw_high, who;
        logic [5:0] seq;

        RESET = 1'b1; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
        #1;
        chk("rst_mem_read", {127'd0, MEM_READ}, '0);
        chk("rst_mem_write", {127'd0, MEM_WRITE}, '0);
        chk("rst_mem_addr", {100'd0, MEM_ADDRESS}, '0);
        chk("rst_i_bw", {127'd0, I_BUSYWAIT}, '0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Lone I-cache read, memory busy 5 cycles
        mem_lat = 5;
        @(negedge CLK);
        I_READ = 1'b1; I_ADDRESS = 28'h0000010;
        @(negedge CLK);
        chk("i_mem_read", {127'd0, MEM_READ}, 128'd1);
        chk("i_mem_addr", {100'd0, MEM_ADDRESS}, 128'h10);
        chk("i_bw_serve", {127'd0, I_BUSYWAIT}, 128'd1);
        wait_resp(1'b0, cyc, ibw_low, dbw_high);
        chk("i_latency", cyc, 7);
        chk("i_rdata", I_READDATA, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        chk("i_d_bw_quiet", {127'd0, dbw_high | D_BUSYWAIT}, '0);
        chk("i_resp_strobe", {127'd0, MEM_READ}, '0);
        I_READ = 1'b0;
        @(negedge CLK);
        chk("i_bw_idle", {127'd0, I_BUSYWAIT}, '0);
        chk("i_rdata_hold", I_READDATA, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);

        // D write-back then read of the same block; payload latched at grant
        mem_lat = 2;
        D_WRITE = 1'b1; D_ADDRESS = 28'h0000020; D_WRITEDATA = {4{32'h1111_1111}};
        @(negedge CLK);
        chk("dw_mem_write", {126'd0, MEM_WRITE, MEM_READ}, 128'b10);
        chk("dw_mem_addr", {100'd0, MEM_ADDRESS}, 128'h20);
        chk("dw_wdata", MEM_WRITEDATA, {4{32'h1111_1111}});
        D_WRITEDATA = '0; D_ADDRESS = 28'h0000070;
        @(negedge CLK);
        chk("dw_wdata_latched", MEM_WRITEDATA, {4{32'h1111_1111}});
        chk("dw_addr_latched", {100'd0, MEM_ADDRESS}, 128'h20);
        wait_resp(1'b1, cyc, ibw_low, dbw_high);
        chk("dw_rdata_unchanged", D_READDATA, '0);
        D_WRITE = 1'b0;
        @(negedge CLK);
        D_READ = 1'b1; D_ADDRESS = 28'h0000020;
        @(negedge CLK);
        chk("dr_mem_read", {126'd0, MEM_WRITE, MEM_READ}, 128'b01);
        wait_resp(1'b1, cyc, ibw_low, dbw_high);
        chk("dr_rdata", D_READDATA, {4{32'h1111_1111}});
        D_READ = 1'b0;

        // Reset in the middle of a write-back
        @(negedge CLK);
        D_WRITE = 1'b1; D_ADDRESS = 28'h0000050; D_WRITEDATA = {4{32'h5555_5555}};
        @(negedge CLK);
        chk("mid_mem_write", {127'd0, MEM_WRITE}, 128'd1);
        #2 RESET = 1'b1;
        #1;
        chk("mid_write_drop", {127'd0, MEM_WRITE}, '0);
        D_WRITE = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_strobes", {126'd0, MEM_READ, MEM_WRITE}, '0);
        chk("post_rst_addr", {100'd0, MEM_ADDRESS}, '0);
        chk("post_rst_wdata", MEM_WRITEDATA, '0);
        chk("post_rst_i_rdata", I_READDATA, '0);
        chk("post_rst_d_rdata", D_READDATA, '0);
        chk("post_rst_bw", {126'd0, I_BUSYWAIT, D_BUSYWAIT}, '0);

        // Simultaneous requests right after reset: D first, then I with no idle gap
        I_READ = 1'b1; I_ADDRESS = 28'h0000030;
        D_READ = 1'b1; D_ADDRESS = 28'h0000040;
        @(negedge CLK);
        chk("cf_first_addr", {100'd0, MEM_ADDRESS}, 128'h40);
        chk("cf_first_read", {127'd0, MEM_READ}, 128'd1);
        wait_resp(1'b1, cyc, ibw_low, dbw_high);
        chk("cf_d_rdata", D_READDATA, {4{32'hA5A5_0004}});
        chk("cf_i_bw_high", {127'd0, ibw_low | !I_BUSYWAIT}, '0);
        D_READ = 1'b0;
        @(negedge CLK);
        chk("cf_i_direct", {99'd0, MEM_READ, MEM_ADDRESS}, {99'd0, 1'b1, 28'h0000030});
        wait_resp(1'b0, cyc, ibw_low, dbw_high);
        chk("cf_i_bw_high2", {127'd0, ibw_low}, '0);
        chk("cf_i_rdata", I_READDATA, {4{32'hA5A5_0003}});
        I_READ = 1'b0;

        // Continuous contention: strict alternation starting with D
        @(negedge CLK);
        I_READ = 1'b1; D_READ = 1'b1;
        seq = '0;
        for (int k = 0; k < 6; k++) begin
            wait_any(who);
            seq[k] = who;
        end
        I_READ = 1'b0; D_READ = 1'b0;
        chk("rr_seq", {122'd0, seq}, 128'b010101);

        // Read and write together: write first, pending read follows
        @(negedge CLK);
        D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 28'h0000060; D_WRITEDATA = {4{32'h2222_2222}};
        @(negedge CLK);
        chk("rw_write_first", {126'd0, MEM_WRITE, MEM_READ}, 128'b10);
        wait_resp(1'b1, cyc, ibw_low, dbw_high);
        chk("rw_rdata_keep", D_READDATA, {4{32'hA5A5_0004}});
        D_WRITE = 1'b0;
        @(negedge CLK);
        chk("rw_read_next", {98'd0, MEM_WRITE, MEM_READ, MEM_ADDRESS}, {98'd0, 2'b01, 28'h0000060});
        wait_resp(1'b1, cyc, ibw_low, dbw_high);
        chk("rw_rdata", D_READDATA, {4{32'h2222_2222}});
        D_READ = 1'b0;
        @(negedge CLK);
        chk("rw_idle_bw", {127'd0, D_BUSYWAIT}, '0);
        chk("rw_rdata_hold", D_READDATA, {4{32'h2222_2222}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
